// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed scan controller for a common-anode,
//               multi-digit 7-segment display. One shared BCD decoder is fed
//               one digit at a time, with a blanking gap between digit slots.
//               New values are double-buffered and committed only at frame
//               boundaries. Leading zeros can optionally be suppressed.
//
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous active-high reset
//               digits_in  - new display value, nibble i = digit i (0 = LSD)
//               load       - capture digits_in into the pending buffer
//               lzb_en     - leading-zero blanking enable (sampled each cycle)
//               bcd        - nibble for the shared decoder (registered)
//               an         - active-low anode enables, at most one low
//               pending    - a captured value is waiting for frame commit
//               frame_done - one-cycle pulse at the frame boundary / commit
//
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 50000,
    parameter int BLANK      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic                      load,
    input  logic                      lzb_en,
    output logic [3:0]                bcd,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      pending,
    output logic                      frame_done
);

    localparam int c_CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [c_CNT_W-1:0] c_BLANK_END = c_CNT_W'(BLANK - 1);
    localparam logic [c_CNT_W-1:0] c_DWELL_END = c_CNT_W'(DWELL - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    // Registered state
    state_t                    r_state;
    logic [c_IDX_W-1:0]        r_idx;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [4*NUM_DIGITS-1:0]   r_disp;
    logic [4*NUM_DIGITS-1:0]   r_buf;
    logic                      r_pending;
    logic [3:0]                r_bcd;
    logic [NUM_DIGITS-1:0]     r_an;
    logic                      r_frame_done;

    // Next-state values
    state_t                    w_state_nxt;
    logic [c_IDX_W-1:0]        w_idx_nxt;
    logic [c_CNT_W-1:0]        w_cnt_nxt;
    logic                      w_boundary;
    logic [4*NUM_DIGITS-1:0]   w_disp_nxt;
    logic [4*NUM_DIGITS-1:0]   w_buf_nxt;
    logic                      w_pending_nxt;
    logic [3:0]                w_bcd_nxt;
    logic [NUM_DIGITS-1:0]     w_an_nxt;
    logic [NUM_DIGITS-1:0]     w_lit;
    logic                      w_acc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_BLANK;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_disp       <= '0;
            r_buf        <= '0;
            r_pending    <= 1'b0;
            r_bcd        <= 4'h0;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_disp       <= w_disp_nxt;
            r_buf        <= w_buf_nxt;
            r_pending    <= w_pending_nxt;
            r_bcd        <= w_bcd_nxt;
            r_an         <= w_an_nxt;
            r_frame_done <= w_boundary;
        end
    end

    // ------------------------------------------------------------------
    // Scan sequencing and double-buffer control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_boundary  = 1'b0;

        case (r_state)
            S_BLANK: begin
                if (r_cnt == c_BLANK_END) begin
                    w_state_nxt = S_SHOW;
                    w_cnt_nxt   = '0;
                end
            end
            S_SHOW: begin
                if (r_cnt == c_DWELL_END) begin
                    w_state_nxt = S_BLANK;
                    w_cnt_nxt   = '0;
                    if (r_idx == c_LAST_IDX) begin
                        w_idx_nxt  = '0;
                        w_boundary = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_BLANK;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase

        // The commit reads the buffer as it stood before this cycle, so a
        // load coinciding with the boundary is held over to the next frame.
        w_disp_nxt    = (w_boundary && r_pending) ? r_buf : r_disp;
        w_buf_nxt     = load ? digits_in : r_buf;
        w_pending_nxt = load | (r_pending & ~w_boundary);
    end

    // ------------------------------------------------------------------
    // Leading-zero suppression: walk from the most significant digit down,
    // accumulating whether any nibble at or above the current one is nonzero.
    // ------------------------------------------------------------------
    always_comb begin
        w_acc = 1'b0;
        w_lit = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_acc    = w_acc | (|w_disp_nxt[4*i +: 4]);
            w_lit[i] = (i == 0) || !lzb_en || w_acc;
        end
    end

    // ------------------------------------------------------------------
    // Output look-ahead: outputs are computed from the next state so the
    // registered bcd/an line up with the state register. bcd follows the
    // slot digit in both BLANK and SHOW so it settles before the anode opens.
    // ------------------------------------------------------------------
    always_comb begin
        w_bcd_nxt = w_disp_nxt[4*w_idx_nxt +: 4];
        w_an_nxt  = '1;
        if ((w_state_nxt == S_SHOW) && w_lit[w_idx_nxt]) begin
            w_an_nxt[w_idx_nxt] = 1'b0;
        end
    end

    assign bcd        = r_bcd;
    assign an         = r_an;
    assign pending    = r_pending;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Self-checking bench for seg_scan_ctrl with NUM_DIGITS=4,
//               DWELL=4, BLANK=2 (24-cycle frame). Table of display values
//               with expected per-slot anode/bcd patterns, plus directed
//               sequences for reset, boundary-cycle load, multiple loads and
//               asynchronous reset mid-scan.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] digits_in;
    logic        load;
    logic        lzb_en;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS (4),
        .DWELL      (4),
        .BLANK      (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .load       (load),
        .lzb_en     (lzb_en),
        .bcd        (bcd),
        .an         (an),
        .pending    (pending),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic        lzb;
        logic [15:0] exp_an;   // nibble d = anode pattern during SHOW of digit d
        logic [15:0] exp_bcd;  // nibble d = bcd during slot of digit d
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Advance to the next frame_done sample, bounded.
    task automatic wait_fd();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (frame_done === 1'b1) return;
        end
        chk("fd_timeout", 32'd0, 32'd1);
    endtask

    // Called at the p=0 sample of a frame; checks 24 cycles and leaves the
    // bench at the p=0 sample of the following frame.
    task automatic check_frame(input logic [15:0] ean, input logic [15:0] ebcd, input string tag);
        int d;
        int q;
        logic [3:0] ea;
        for (int c = 0; c < 24; c++) begin
            d  = c / 6;
            q  = c % 6;
            ea = (q < 2) ? 4'hF : ean[d*4 +: 4];
            chk($sformatf("%s_an_c%0d", tag, c), {28'd0, an}, {28'd0, ea});
            chk($sformatf("%s_bcd_c%0d", tag, c), {28'd0, bcd}, {28'd0, ebcd[d*4 +: 4]});
            chk($sformatf("%s_fd_c%0d", tag, c), {31'd0, frame_done}, {31'd0, (c == 0)});
            @(negedge clk);
        end
    endtask

    // Called at a negedge with rst high; releases reset and checks the
    // first 25 cycles (display is zero, lzb off).
    task automatic startup_check(input string tag);
        int p;
        logic [3:0] ea;
        rst = 1'b0;
        #1;
        for (int k = 0; k <= 24; k++) begin
            if (k > 0) @(negedge clk);
            p  = k % 24;
            ea = ((p % 6) < 2) ? 4'hF : ~(4'b0001 << (p / 6));
            chk($sformatf("%s_an_k%0d", tag, k), {28'd0, an}, {28'd0, ea});
            chk($sformatf("%s_bcd_k%0d", tag, k), {28'd0, bcd}, 32'd0);
            chk($sformatf("%s_fd_k%0d", tag, k), {31'd0, frame_done}, {31'd0, (k == 24)});
        end
    endtask

    initial begin
        vecs[0] = '{val: 16'h0070, lzb: 1'b1, exp_an: 16'hFFDE, exp_bcd: 16'h0070};
        vecs[1] = '{val: 16'h0000, lzb: 1'b1, exp_an: 16'hFFFE, exp_bcd: 16'h0000};
        vecs[2] = '{val: 16'h0000, lzb: 1'b0, exp_an: 16'h7BDE, exp_bcd: 16'h0000};
        vecs[3] = '{val: 16'hA0B0, lzb: 1'b1, exp_an: 16'h7BDE, exp_bcd: 16'hA0B0};
        vecs[4] = '{val: 16'h0105, lzb: 1'b1, exp_an: 16'hFBDE, exp_bcd: 16'h0105};
        vecs[5] = '{val: 16'h0070, lzb: 1'b0, exp_an: 16'h7BDE, exp_bcd: 16'h0070};
        vecs[6] = '{val: 16'h9876, lzb: 1'b1, exp_an: 16'h7BDE, exp_bcd: 16'h9876};

        rst       = 1'b1;
        digits_in = 16'h0;
        load      = 1'b0;
        lzb_en    = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_bcd", {28'd0, bcd}, 32'd0);
        chk("rst_pending", {31'd0, pending}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);

        // Startup scan timing; ends at p=0 of the second frame
        startup_check("start");

        // Load mid digit 2, pending held until boundary
        repeat (14) @(negedge clk);
        digits_in = 16'h1234;
        load      = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("ld1234_pending_set", {31'd0, pending}, 32'd1);
        for (int k = 16; k <= 24; k++) begin
            @(negedge clk);
            chk($sformatf("ld1234_pending_p%0d", k), {31'd0, pending}, {31'd0, (k < 24)});
            chk($sformatf("ld1234_fd_p%0d", k), {31'd0, frame_done}, {31'd0, (k == 24)});
        end
        check_frame(16'h7BDE, 16'h1234, "f1234");

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            digits_in = vecs[i].val;
            lzb_en    = vecs[i].lzb;
            load      = 1'b1;
            @(negedge clk);
            load = 1'b0;
            chk($sformatf("v%0d_pending_set", i), {31'd0, pending}, 32'd1);
            wait_fd();
            chk($sformatf("v%0d_pending_clr", i), {31'd0, pending}, 32'd0);
            check_frame(vecs[i].exp_an, vecs[i].exp_bcd, $sformatf("v%0d", i));
        end

        // Load in the exact boundary cycle while AAAA is pending
        lzb_en    = 1'b0;
        digits_in = 16'hAAAA;
        load      = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (22) @(negedge clk);
        digits_in = 16'h5555;
        load      = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("bnd_fd", {31'd0, frame_done}, 32'd1);
        chk("bnd_pending_kept", {31'd0, pending}, 32'd1);
        check_frame(16'h7BDE, 16'hAAAA, "bndA");
        chk("bnd5_pending_clr", {31'd0, pending}, 32'd0);
        check_frame(16'h7BDE, 16'h5555, "bnd5");

        // Two loads in one frame: the last wins, single commit
        repeat (3) @(negedge clk);
        digits_in = 16'h1111;
        load      = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (6) @(negedge clk);
        digits_in = 16'h2222;
        load      = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_fd();
        chk("dbl_pending_clr", {31'd0, pending}, 32'd0);
        check_frame(16'h7BDE, 16'h2222, "dbl1");
        chk("dbl_pending_still_clr", {31'd0, pending}, 32'd0);
        check_frame(16'h7BDE, 16'h2222, "dbl2");

        // Asynchronous reset in the middle of a SHOW slot
        repeat (3) @(negedge clk);
        chk("arst_pre_an", {28'd0, an}, 32'hE);
        chk("arst_pre_bcd", {28'd0, bcd}, 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_an", {28'd0, an}, 32'hF);
        chk("arst_bcd", {28'd0, bcd}, 32'd0);
        chk("arst_pending", {31'd0, pending}, 32'd0);
        chk("arst_fd", {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        startup_check("restart");
        chk("restart_pending", {31'd0, pending}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit as a backstop against hangs.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
